// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: run controller for the minimal SOPC.
// Stretches the board reset into a core reset of RST_HOLD cycles, counts run
// cycles, detects end of program by PC stagnation ("j ." self-loop) and flags
// a timeout after MAX_CYCLES run cycles (0 disables the timeout).
// Optional macro SOPC_RUN_PCCHG_EN adds pc_chg_cnt_o and first_pc_o.
module sopc_run_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 32,
    parameter int RST_HOLD    = 4,
    parameter int HALT_CYCLES = 8,
    parameter int MAX_CYCLES  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              restart_i,
    output logic              core_rst_o,
    output logic              running_o,
    output logic              done_o,
    output logic              halted_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [ADDR_W-1:0] halt_pc_o
`ifdef SOPC_RUN_PCCHG_EN
    ,
    output logic [CNT_W-1:0]  pc_chg_cnt_o,
    output logic [ADDR_W-1:0] first_pc_o
`endif
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int SAME_W = $clog2(HALT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [SAME_W-1:0] SAME_LAST = SAME_W'(HALT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SAME_W-1:0]   same_cnt_q, same_cnt_d;
    logic                pc_valid_q, pc_valid_d;
    logic [ADDR_W-1:0]   prev_pc_q, prev_pc_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [ADDR_W-1:0]   halt_pc_q, halt_pc_d;
    logic                core_rst_q, core_rst_d;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic                halted_q, halted_d;
    logic                timeout_q, timeout_d;
`ifdef SOPC_RUN_PCCHG_EN
    logic [CNT_W-1:0]    pc_chg_cnt_q, pc_chg_cnt_d;
    logic [ADDR_W-1:0]   first_pc_q, first_pc_d;
`endif

    logic [CNT_W-1:0]    cycle_inc;
    logic                pc_match;
    logic                halt_hit;
    logic                timeout_hit;

    // Saturating cycle increment and the halt/timeout conditions seen this edge
    always_comb begin
        cycle_inc   = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        pc_match    = pc_valid_q && (pc_i == prev_pc_q);
        halt_hit    = pc_match && (same_cnt_q == SAME_LAST);
        timeout_hit = (MAX_CYCLES != 0) && (cycle_inc == MAX_CNT);
    end

    // Next-state and registered-output logic; restart clears everything in any state
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        same_cnt_d  = same_cnt_q;
        pc_valid_d  = pc_valid_q;
        prev_pc_d   = prev_pc_q;
        cycle_cnt_d = cycle_cnt_q;
        halt_pc_d   = halt_pc_q;
        core_rst_d  = core_rst_q;
        running_d   = running_q;
        done_d      = done_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
`ifdef SOPC_RUN_PCCHG_EN
        pc_chg_cnt_d = pc_chg_cnt_q;
        first_pc_d   = first_pc_q;
`endif
        if (restart_i) begin
            state_d     = S_RESET;
            hold_cnt_d  = '0;
            same_cnt_d  = '0;
            pc_valid_d  = 1'b0;
            prev_pc_d   = '0;
            cycle_cnt_d = '0;
            halt_pc_d   = '0;
            core_rst_d  = 1'b1;
            running_d   = 1'b0;
            done_d      = 1'b0;
            halted_d    = 1'b0;
            timeout_d   = 1'b0;
`ifdef SOPC_RUN_PCCHG_EN
            pc_chg_cnt_d = '0;
            first_pc_d   = '0;
`endif
        end else begin
            case (state_q)
                S_RESET: begin
                    core_rst_d = 1'b1;
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = S_RUN;
                        core_rst_d = 1'b0;
                        running_d  = 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_cnt_d = cycle_inc;
                    prev_pc_d   = pc_i;
                    if (!pc_valid_q) begin
                        pc_valid_d = 1'b1;
`ifdef SOPC_RUN_PCCHG_EN
                        first_pc_d = pc_i;
`endif
                    end else if (pc_match) begin
                        same_cnt_d = same_cnt_q + 1'b1;
                    end else begin
                        same_cnt_d = '0;
`ifdef SOPC_RUN_PCCHG_EN
                        if (pc_chg_cnt_q != '1) begin
                            pc_chg_cnt_d = pc_chg_cnt_q + 1'b1;
                        end
`endif
                    end
                    if (halt_hit) begin
                        state_d   = S_HALTED;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                        halted_d  = 1'b1;
                        halt_pc_d = pc_i;
                    end else if (timeout_hit) begin
                        state_d   = S_TIMEOUT;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET;
            hold_cnt_q  <= '0;
            same_cnt_q  <= '0;
            pc_valid_q  <= 1'b0;
            prev_pc_q   <= '0;
            cycle_cnt_q <= '0;
            halt_pc_q   <= '0;
            core_rst_q  <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef SOPC_RUN_PCCHG_EN
            pc_chg_cnt_q <= '0;
            first_pc_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            same_cnt_q  <= same_cnt_d;
            pc_valid_q  <= pc_valid_d;
            prev_pc_q   <= prev_pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            halt_pc_q   <= halt_pc_d;
            core_rst_q  <= core_rst_d;
            running_q   <= running_d;
            done_q      <= done_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
`ifdef SOPC_RUN_PCCHG_EN
            pc_chg_cnt_q <= pc_chg_cnt_d;
            first_pc_q   <= first_pc_d;
`endif
        end
    end

    assign core_rst_o  = core_rst_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
    assign halted_o    = halted_q;
    assign timeout_o   = timeout_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign halt_pc_o   = halt_pc_q;
`ifdef SOPC_RUN_PCCHG_EN
    assign pc_chg_cnt_o = pc_chg_cnt_q;
    assign first_pc_o   = first_pc_q;
`endif

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// tb_sopc_run_ctrl: scoreboard bench for sopc_run_ctrl
// (RST_HOLD=4, HALT_CYCLES=8, MAX_CYCLES=20).
module tb_sopc_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic        restart_i = 1'b0;
    logic        core_rst_o, running_o, done_o, halted_o, timeout_o;
    logic [31:0] cycle_cnt_o, halt_pc_o;
`ifdef SOPC_RUN_PCCHG_EN
    logic [31:0] pc_chg_cnt_o, first_pc_o;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Expected end-of-run result, pushed when a run's stimulus is set up
    typedef struct {
        logic        halted;
        logic        timeout;
        logic [31:0] cnt;
        logic [31:0] hpc;
        logic [31:0] chg;
        logic [31:0] fpc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] pc_seq[$];

    sopc_run_ctrl #(
        .ADDR_W(32), .CNT_W(32), .RST_HOLD(4), .HALT_CYCLES(8), .MAX_CYCLES(20)
    ) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .restart_i(restart_i),
        .core_rst_o(core_rst_o), .running_o(running_o), .done_o(done_o),
        .halted_o(halted_o), .timeout_o(timeout_o),
        .cycle_cnt_o(cycle_cnt_o), .halt_pc_o(halt_pc_o)
`ifdef SOPC_RUN_PCCHG_EN
        , .pc_chg_cnt_o(pc_chg_cnt_o), .first_pc_o(first_pc_o)
`endif
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until running_o rises, reporting whether it did within the budget
    task automatic wait_running(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (running_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Apply board reset then wait for the core to be released
    task automatic bring_up(output bit ok);
        rst = 1'b1;
        restart_i = 1'b0;
        pc_i = '0;
        repeat (2) step();
        rst = 1'b0;
        wait_running(10, ok);
    endtask

    // Drive pc_seq one entry per RUN edge, holding the last entry, until done_o
    task automatic run_seq(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            pc_i = (i < pc_seq.size()) ? pc_seq[i] : pc_seq[pc_seq.size() - 1];
            step();
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reset values, then core_rst_o held for 4 edges with rst low
    task automatic test_reset();
        rst = 1'b1;
        restart_i = 1'b0;
        pc_i = '0;
        repeat (3) step();
        n_checks++;
        if ({core_rst_o, running_o, done_o, halted_o, timeout_o} !== 5'b10000) begin
            n_fails++;
            $display("[TB] FAIL reset_flags: got %b expected 10000",
                     {core_rst_o, running_o, done_o, halted_o, timeout_o});
        end
        n_checks++;
        if (cycle_cnt_o !== 32'd0 || halt_pc_o !== 32'd0) begin
            n_fails++;
            $display("[TB] FAIL reset_counters: got cnt=%0d hpc=%h expected 0/0", cycle_cnt_o, halt_pc_o);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (core_rst_o !== (k < 4) || running_o !== (k == 4)) begin
                n_fails++;
                $display("[TB] FAIL stretch_edge%0d: got core_rst=%b running=%b expected %b/%b",
                         k, core_rst_o, running_o, (k < 4), (k == 4));
            end
        end
    endtask

    // PCs 0,4,8 then 0xC held: 0xC first seen on edge 4, edges 5..12 are the 8 matches
    task automatic test_halt();
        bit   ok;
        exp_t e;
        pc_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
        sb_q.push_back('{halted: 1'b1, timeout: 1'b0, cnt: 32'd12, hpc: 32'hC, chg: 32'd3, fpc: 32'h0});
        bring_up(ok);
        if (ok) run_seq(40, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("[TB] FAIL halt_done: got no done_o expected done within budget");
        end
        n_checks++;
        if (halted_o !== e.halted || timeout_o !== e.timeout || done_o !== 1'b1 || running_o !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL halt_flags: got h=%b t=%b d=%b r=%b expected 1/0/1/0",
                     halted_o, timeout_o, done_o, running_o);
        end
        n_checks++;
        if (cycle_cnt_o !== e.cnt || halt_pc_o !== e.hpc) begin
            n_fails++;
            $display("[TB] FAIL halt_values: got cnt=%0d hpc=%h expected %0d/%h", cycle_cnt_o, halt_pc_o, e.cnt, e.hpc);
        end
`ifdef SOPC_RUN_PCCHG_EN
        n_checks++;
        if (pc_chg_cnt_o !== e.chg || first_pc_o !== e.fpc) begin
            n_fails++;
            $display("[TB] FAIL halt_pcchg: got chg=%0d fpc=%h expected %0d/%h", pc_chg_cnt_o, first_pc_o, e.chg, e.fpc);
        end
`endif
        pc_i = 32'h40;
        repeat (5) step();
        n_checks++;
        if (cycle_cnt_o !== e.cnt || halt_pc_o !== e.hpc || halted_o !== 1'b1 || core_rst_o !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL halt_frozen: got cnt=%0d hpc=%h h=%b cr=%b expected %0d/%h/1/0",
                     cycle_cnt_o, halt_pc_o, halted_o, core_rst_o, e.cnt, e.hpc);
        end
    endtask

    // PC increments every edge, so only the 20-cycle timeout can end the run
    task automatic test_timeout();
        bit   ok;
        exp_t e;
        pc_seq = {};
        for (int i = 0; i < 40; i++) pc_seq.push_back(32'h100 + 32'(4 * i));
        sb_q.push_back('{halted: 1'b0, timeout: 1'b1, cnt: 32'd20, hpc: 32'h0, chg: 32'd19, fpc: 32'h100});
        bring_up(ok);
        if (ok) run_seq(40, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || timeout_o !== e.timeout || halted_o !== e.halted || done_o !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL timeout_flags: got ok=%b t=%b h=%b d=%b expected 1/1/0/1", ok, timeout_o, halted_o, done_o);
        end
        n_checks++;
        if (cycle_cnt_o !== e.cnt || halt_pc_o !== e.hpc) begin
            n_fails++;
            $display("[TB] FAIL timeout_values: got cnt=%0d hpc=%h expected %0d/%h", cycle_cnt_o, halt_pc_o, e.cnt, e.hpc);
        end
`ifdef SOPC_RUN_PCCHG_EN
        n_checks++;
        if (pc_chg_cnt_o !== e.chg || first_pc_o !== e.fpc) begin
            n_fails++;
            $display("[TB] FAIL timeout_pcchg: got chg=%0d fpc=%h expected %0d/%h", pc_chg_cnt_o, first_pc_o, e.chg, e.fpc);
        end
`endif
        for (int i = 0; i < 10; i++) begin
            pc_i = pc_i + 32'd4;
            step();
        end
        n_checks++;
        if (cycle_cnt_o !== 32'd20 || timeout_o !== 1'b1 || running_o !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL timeout_frozen: got cnt=%0d t=%b r=%b expected 20/1/0", cycle_cnt_o, timeout_o, running_o);
        end
    endtask

    // 12 distinct PCs then hold: 8th match lands on edge 20, same edge as timeout
    task automatic test_tie();
        bit   ok;
        exp_t e;
        pc_seq = {};
        for (int i = 0; i < 12; i++) pc_seq.push_back(32'h200 + 32'(4 * i));
        sb_q.push_back('{halted: 1'b1, timeout: 1'b0, cnt: 32'd20, hpc: 32'h22C, chg: 32'd11, fpc: 32'h200});
        bring_up(ok);
        if (ok) run_seq(40, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || halted_o !== e.halted || timeout_o !== e.timeout) begin
            n_fails++;
            $display("[TB] FAIL tie_flags: got ok=%b h=%b t=%b expected 1/1/0", ok, halted_o, timeout_o);
        end
        n_checks++;
        if (cycle_cnt_o !== e.cnt || halt_pc_o !== e.hpc) begin
            n_fails++;
            $display("[TB] FAIL tie_values: got cnt=%0d hpc=%h expected %0d/%h", cycle_cnt_o, halt_pc_o, e.cnt, e.hpc);
        end
`ifdef SOPC_RUN_PCCHG_EN
        n_checks++;
        if (pc_chg_cnt_o !== e.chg || first_pc_o !== e.fpc) begin
            n_fails++;
            $display("[TB] FAIL tie_pcchg: got chg=%0d fpc=%h expected %0d/%h", pc_chg_cnt_o, first_pc_o, e.chg, e.fpc);
        end
`endif
    endtask

    // Restart from HALTED clears everything and a repeat run halts identically
    task automatic test_restart();
        bit   ok;
        exp_t e;
        pc_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
        sb_q.push_back('{halted: 1'b1, timeout: 1'b0, cnt: 32'd12, hpc: 32'hC, chg: 32'd3, fpc: 32'h0});
        sb_q.push_back('{halted: 1'b1, timeout: 1'b0, cnt: 32'd12, hpc: 32'hC, chg: 32'd3, fpc: 32'h0});
        bring_up(ok);
        if (ok) run_seq(40, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || halted_o !== e.halted || cycle_cnt_o !== e.cnt) begin
            n_fails++;
            $display("[TB] FAIL restart_first_run: got ok=%b h=%b cnt=%0d expected 1/1/%0d", ok, halted_o, cycle_cnt_o, e.cnt);
        end
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        n_checks++;
        if ({core_rst_o, running_o, done_o, halted_o, timeout_o} !== 5'b10000
            || cycle_cnt_o !== 32'd0 || halt_pc_o !== 32'd0) begin
            n_fails++;
            $display("[TB] FAIL restart_clear: got flags=%b cnt=%0d hpc=%h expected 10000/0/0",
                     {core_rst_o, running_o, done_o, halted_o, timeout_o}, cycle_cnt_o, halt_pc_o);
        end
`ifdef SOPC_RUN_PCCHG_EN
        n_checks++;
        if (pc_chg_cnt_o !== 32'd0 || first_pc_o !== 32'd0) begin
            n_fails++;
            $display("[TB] FAIL restart_pcchg_clear: got chg=%0d fpc=%h expected 0/0", pc_chg_cnt_o, first_pc_o);
        end
`endif
        wait_running(10, ok);
        if (ok) run_seq(40, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || halted_o !== e.halted || cycle_cnt_o !== e.cnt || halt_pc_o !== e.hpc) begin
            n_fails++;
            $display("[TB] FAIL restart_second_run: got ok=%b h=%b cnt=%0d hpc=%h expected 1/1/%0d/%h",
                     ok, halted_o, cycle_cnt_o, halt_pc_o, e.cnt, e.hpc);
        end
    endtask

    // Restart during RESET restarts the hold count: 4 more edges to RUN
    task automatic test_restart_in_reset();
        int edges;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        edges = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            edges++;
            if (running_o) break;
        end
        n_checks++;
        if (edges !== 4 || running_o !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL restart_in_reset: got %0d edges running=%b expected 4/1", edges, running_o);
        end
    endtask

    // rst asserted mid-run returns every output to its reset value
    task automatic test_reset_mid_run();
        bit ok;
        bring_up(ok);
        pc_i = 32'h300;
        for (int i = 0; i < 20 && ok; i++) begin
            step();
            if (cycle_cnt_o == 32'd5) break;
            pc_i = pc_i + 32'd4;
        end
        n_checks++;
        if (!ok || cycle_cnt_o !== 32'd5 || running_o !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL midrun_reach5: got ok=%b cnt=%0d r=%b expected 1/5/1", ok, cycle_cnt_o, running_o);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({core_rst_o, running_o, done_o, halted_o, timeout_o} !== 5'b10000
            || cycle_cnt_o !== 32'd0 || halt_pc_o !== 32'd0) begin
            n_fails++;
            $display("[TB] FAIL midrun_reset: got flags=%b cnt=%0d hpc=%h expected 10000/0/0",
                     {core_rst_o, running_o, done_o, halted_o, timeout_o}, cycle_cnt_o, halt_pc_o);
        end
`ifdef SOPC_RUN_PCCHG_EN
        n_checks++;
        if (pc_chg_cnt_o !== 32'd0 || first_pc_o !== 32'd0) begin
            n_fails++;
            $display("[TB] FAIL midrun_pcchg: got chg=%0d fpc=%h expected 0/0", pc_chg_cnt_o, first_pc_o);
        end
`endif
        rst = 1'b0;
    endtask

    // Run every scenario in sequence then report
    initial begin
        $display("[TB] starting sopc_run_ctrl bench");
        test_reset();
        test_halt();
        test_timeout();
        test_tie();
        test_restart();
        test_restart_in_reset();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time bound so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
